// File: rtl/capacity_pkg.sv
// capacity_pkg
//   Shared definitions for the capacity tracker slice:
//   - state_t     : occupancy state encoding driven onto the 2-bit state port
//   - STATE_W     : width of the state port
//   - MAX_CH      : widest enter/exit channel vector the popcount helper accepts
//   - popcount()  : number of set bits in a (zero-padded) channel vector
package capacity_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned MAX_CH  = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_EMPTY  = 2'b00,
        ST_NORMAL = 2'b01,
        ST_FULL   = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    function automatic logic [2:0] popcount(input logic [MAX_CH-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (v[i]) begin
                n = n + 3'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/capacity_grant_arb.sv
// capacity_grant_arb
//   Combinational fixed-priority grant: walks the request vector from index 0
//   upward and grants each active request while fewer than `room` grants have
//   been issued. Remaining requests are dropped for this cycle.
// Ports
//   req       in   N_CH  per-channel entry requests
//   room      in   RW    free slots available this cycle
//   grant     out  N_CH  granted requests (subset of req)
//   grant_cnt out  RW    number of bits set in grant (never exceeds room)
module capacity_grant_arb #(
    parameter int unsigned N_CH = 2,
    parameter int unsigned RW   = 5
) (
    input  logic [N_CH-1:0] req,
    input  logic [RW-1:0]   room,
    output logic [N_CH-1:0] grant,
    output logic [RW-1:0]   grant_cnt
);

    always_comb begin
        grant     = '0;
        grant_cnt = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (req[i] && (grant_cnt < room)) begin
                grant[i]  = 1'b1;
                grant_cnt = grant_cnt + RW'(1);
            end
        end
    end

endmodule

// File: rtl/capacity_tracker.sv
// capacity_tracker
//   Registered occupancy tracker. Each edge it retires exit events (clipped at
//   zero), admits entry requests in priority order up to the remaining room
//   under cap_max, optionally replaces cap_max with a legal cap_des, and
//   registers the resulting occupancy state and event pulses.
// Ports
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high; overrides all inputs
//   cap_load     in   1      replace cap_max with cap_des this cycle
//   cap_des      in   WIDTH  desired capacity (legal range 1..CAP_LIMIT)
//   enter_req    in   N_CH   per-channel entry request level
//   exit_pulse   in   N_CH   per-channel exit event, one person per bit
//   enter_grant  out  N_CH   registered grants for the requests of last edge
//   count        out  WIDTH  registered occupancy
//   cap_max      out  WIDTH  registered active capacity
//   state        out  2      00 EMPTY, 01 NORMAL, 10 FULL, 11 OVER
//   reject_load  out  1      one-cycle pulse: illegal cap_des refused
//   underflow    out  1      one-cycle pulse: exits exceeded occupancy
module capacity_tracker
    import capacity_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned N_CH        = 2,
    parameter int unsigned CAP_LIMIT   = 12,
    parameter int unsigned CAP_DEFAULT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cap_load,
    input  logic [WIDTH-1:0]   cap_des,
    input  logic [N_CH-1:0]    enter_req,
    input  logic [N_CH-1:0]    exit_pulse,
    output logic [N_CH-1:0]    enter_grant,
    output logic [WIDTH-1:0]   count,
    output logic [WIDTH-1:0]   cap_max,
    output logic [STATE_W-1:0] state,
    output logic               reject_load,
    output logic               underflow
);

    // One bit of headroom over WIDTH, but never narrower than a popcount result.
    localparam int unsigned AW = (WIDTH + 1 > 3) ? WIDTH + 1 : 3;

    localparam logic [WIDTH-1:0] CAP_LIM_W = WIDTH'(CAP_LIMIT);
    localparam logic [WIDTH-1:0] CAP_DEF_W = WIDTH'(CAP_DEFAULT);

    state_t state_q, state_next;

    logic [AW-1:0]    cnt_ext, cap_ext, ex, ex_eff, remain, room, grant_cnt;
    logic [N_CH-1:0]  grant;
    logic             uf_next, load_ok, rej_next;
    logic [WIDTH-1:0] count_next, cap_next;

    // Exits are retired before admission so slots freed this cycle can be reused.
    always_comb begin
        cnt_ext = AW'(count);
        cap_ext = AW'(cap_max);
        ex      = AW'(popcount(MAX_CH'(exit_pulse)));
        uf_next = (ex > cnt_ext);
        ex_eff  = uf_next ? cnt_ext : ex;
        remain  = cnt_ext - ex_eff;
        // Admission always uses the cap_max currently held, even on a load edge.
        room    = (remain >= cap_ext) ? '0 : (cap_ext - remain);
    end

    capacity_grant_arb #(
        .N_CH (N_CH),
        .RW   (AW)
    ) u_arb (
        .req       (enter_req),
        .room      (room),
        .grant     (grant),
        .grant_cnt (grant_cnt)
    );

    always_comb begin
        count_next = WIDTH'(remain + grant_cnt);
        load_ok    = cap_load && (cap_des != '0) && (cap_des <= CAP_LIM_W);
        rej_next   = cap_load && !load_ok;
        cap_next   = load_ok ? cap_des : cap_max;
    end

    // State reflects the post-edge occupancy against the post-edge capacity.
    always_comb begin
        state_next = ST_NORMAL;
        if (count_next == '0) begin
            state_next = ST_EMPTY;
        end else if (count_next > cap_next) begin
            state_next = ST_OVER;
        end else if (count_next == cap_next) begin
            state_next = ST_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            count       <= '0;
            cap_max     <= CAP_DEF_W;
            enter_grant <= '0;
            reject_load <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state_q     <= state_next;
            count       <= count_next;
            cap_max     <= cap_next;
            enter_grant <= grant;
            reject_load <= rej_next;
            underflow   <= uf_next;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_capacity_tracker.sv
// tb_capacity_tracker
//   Directed, table-driven bench for capacity_tracker with default parameters
//   (WIDTH=4, N_CH=2, CAP_LIMIT=12, CAP_DEFAULT=8). Each table row gives the
//   inputs for one clock edge and the outputs expected just after that edge.
module tb_capacity_tracker;

    localparam logic [1:0] S_EMPTY  = 2'b00;
    localparam logic [1:0] S_NORMAL = 2'b01;
    localparam logic [1:0] S_FULL   = 2'b10;
    localparam logic [1:0] S_OVER   = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       cap_load;
    logic [3:0] cap_des;
    logic [1:0] enter_req;
    logic [1:0] exit_pulse;
    logic [1:0] enter_grant;
    logic [3:0] count;
    logic [3:0] cap_max;
    logic [1:0] state;
    logic       reject_load;
    logic       underflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    capacity_tracker #(
        .WIDTH       (4),
        .N_CH        (2),
        .CAP_LIMIT   (12),
        .CAP_DEFAULT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cap_load    (cap_load),
        .cap_des     (cap_des),
        .enter_req   (enter_req),
        .exit_pulse  (exit_pulse),
        .enter_grant (enter_grant),
        .count       (count),
        .cap_max     (cap_max),
        .state       (state),
        .reject_load (reject_load),
        .underflow   (underflow)
    );

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] des;
        logic [1:0] req;
        logic [1:0] ex;
        logic [1:0] g;
        logic [3:0] c;
        logic [3:0] cap;
        logic [1:0] st;
        logic       rj;
        logic       uf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic ld, input logic [3:0] des,
                                input logic [1:0] req, input logic [1:0] ex,
                                input logic [1:0] g, input logic [3:0] c,
                                input logic [3:0] cap, input logic [1:0] st,
                                input logic rj, input logic uf);
        vec_t v;
        v.rst = rst; v.ld = ld; v.des = des; v.req = req; v.ex = ex;
        v.g = g; v.c = c; v.cap = cap; v.st = st; v.rj = rj; v.uf = uf;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic ld, input logic [3:0] des,
                        input logic [1:0] req, input logic [1:0] ex);
        @(negedge clk);
        reset      = rst;
        cap_load   = ld;
        cap_des    = des;
        enter_req  = req;
        exit_pulse = ex;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [1:0] g, input logic [3:0] c,
                             input logic [3:0] cap, input logic [1:0] st,
                             input logic rj, input logic uf);
        check({tag, ".grant"},     8'(enter_grant), 8'(g));
        check({tag, ".count"},     8'(count),       8'(c));
        check({tag, ".cap_max"},   8'(cap_max),     8'(cap));
        check({tag, ".state"},     8'(state),       8'(st));
        check({tag, ".reject"},    8'(reject_load), 8'(rj));
        check({tag, ".underflow"}, 8'(underflow),   8'(uf));
    endtask

    initial begin
        reset = 1'b1; cap_load = 1'b0; cap_des = '0; enter_req = '0; exit_pulse = '0;

        //             rst ld des    req    ex    | g      c      cap     st        rj uf
        vecs.push_back(mk(1, 0, 4'd0,  2'b00, 2'b00, 2'b00, 4'd0, 4'd8,  S_EMPTY,  0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b00, 2'b00, 2'b00, 4'd0, 4'd8,  S_EMPTY,  0, 0));
        // Fill two per cycle up to the default cap of 8
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b00, 2'b11, 4'd2, 4'd8,  S_NORMAL, 0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b00, 2'b11, 4'd4, 4'd8,  S_NORMAL, 0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b00, 2'b11, 4'd6, 4'd8,  S_NORMAL, 0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b00, 2'b11, 4'd8, 4'd8,  S_FULL,   0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b00, 2'b00, 4'd8, 4'd8,  S_FULL,   0, 0));
        // Exits free room in the same cycle
        vecs.push_back(mk(0, 0, 4'd0,  2'b01, 2'b10, 2'b01, 4'd8, 4'd8,  S_FULL,   0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b11, 2'b11, 4'd8, 4'd8,  S_FULL,   0, 0));
        // Lower cap below occupancy, raise back, lower again
        vecs.push_back(mk(0, 1, 4'd5,  2'b00, 2'b00, 2'b00, 4'd8, 4'd5,  S_OVER,   0, 0));
        vecs.push_back(mk(0, 1, 4'd8,  2'b00, 2'b00, 2'b00, 4'd8, 4'd8,  S_FULL,   0, 0));
        vecs.push_back(mk(0, 1, 4'd5,  2'b00, 2'b00, 2'b00, 4'd8, 4'd5,  S_OVER,   0, 0));
        // OVER drains with no grants despite requests
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b11, 2'b00, 4'd6, 4'd5,  S_OVER,   0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b01, 2'b00, 4'd5, 4'd5,  S_FULL,   0, 0));
        // Illegal loads
        vecs.push_back(mk(0, 1, 4'd0,  2'b00, 2'b00, 2'b00, 4'd5, 4'd5,  S_FULL,   1, 0));
        vecs.push_back(mk(0, 1, 4'd13, 2'b00, 2'b00, 2'b00, 4'd5, 4'd5,  S_FULL,   1, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b00, 2'b00, 2'b00, 4'd5, 4'd5,  S_FULL,   0, 0));
        // Legal load at CAP_LIMIT: admission on that edge still uses old cap 5
        vecs.push_back(mk(0, 1, 4'd12, 2'b11, 2'b00, 2'b00, 4'd5, 4'd12, S_NORMAL, 0, 0));
        vecs.push_back(mk(0, 0, 4'd0,  2'b11, 2'b00, 2'b11, 4'd7, 4'd12, S_NORMAL, 0, 0));
        vecs.push_back(mk(0, 1, 4'd7,  2'b00, 2'b01, 2'b00, 4'd6, 4'd7,  S_NORMAL, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].des, vecs[i].req, vecs[i].ex);
            check_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].c, vecs[i].cap,
                      vecs[i].st, vecs[i].rj, vecs[i].uf);
        end

        // Underflow from count=1, coinciding with a rejected load
        step(1, 0, 4'd0, 2'b00, 2'b00);
        check_all("uf_reset", 2'b00, 4'd0, 4'd8, S_EMPTY, 0, 0);
        step(0, 0, 4'd0, 2'b01, 2'b00);
        check_all("uf_one", 2'b01, 4'd1, 4'd8, S_NORMAL, 0, 0);
        step(0, 1, 4'd15, 2'b00, 2'b11);
        check_all("uf_pulse", 2'b00, 4'd0, 4'd8, S_EMPTY, 1, 1);
        step(0, 0, 4'd0, 2'b00, 2'b00);
        check_all("uf_clear", 2'b00, 4'd0, 4'd8, S_EMPTY, 0, 0);

        // Reset mid-fill overrides active requests and a legal load
        step(0, 0, 4'd0, 2'b11, 2'b00);
        check_all("mf_fill1", 2'b11, 4'd2, 4'd8, S_NORMAL, 0, 0);
        step(0, 0, 4'd0, 2'b11, 2'b00);
        check_all("mf_fill2", 2'b11, 4'd4, 4'd8, S_NORMAL, 0, 0);
        step(1, 1, 4'd3, 2'b11, 2'b01);
        check_all("mf_reset", 2'b00, 4'd0, 4'd8, S_EMPTY, 0, 0);
        step(0, 0, 4'd0, 2'b00, 2'b00);
        check_all("mf_idle", 2'b00, 4'd0, 4'd8, S_EMPTY, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
